// File: rtl/hpu_pkg.sv
// Shared register-map offsets, bit indices, field widths and the AXI-Lite FSM state type
// for the HPU control register block.
package hpu_pkg;

  localparam int ADDR_W = 20;
  localparam int ITEM_W = 16;

  localparam logic [11:0] CTRL_OFS     = 12'h000;
  localparam logic [11:0] STATUS_OFS   = 12'h004;
  localparam logic [11:0] ADDR_I_OFS   = 12'h008;
  localparam logic [11:0] ADDR_J_OFS   = 12'h00C;
  localparam logic [11:0] ITEM_NUM_OFS = 12'h010;
  localparam logic [11:0] VERSION_OFS  = 12'h014;
  localparam logic [11:0] USER_BASE    = 12'h020;

  localparam int CTRL_GEN_BIT    = 0;
  localparam int CTRL_RUN_BIT    = 1;
  localparam int CTRL_IRQ_EN_BIT = 8;

  localparam int STAT_GEN_BIT  = 0;
  localparam int STAT_RUN_BIT  = 1;
  localparam int STAT_DONE_BIT = 2;
  localparam int STAT_GFS_BIT  = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AW,
    ST_W,
    ST_WRESP,
    ST_RD,
    ST_RRESP
  } axil_state_e;

  // Merge new_v into old_v one byte lane at a time, honouring the write strobes.
  function automatic logic [31:0] apply_strb(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  strb);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/axil_slave_fsm.sv
// AXI-Lite slave handshake FSM: captures write/read requests and presents one-cycle
// wr_en / rd_en strobes to the register file; rdata is captured from rd_data_i.
module axil_slave_fsm
  import hpu_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [11:0] s_axi_awaddr_i,
  input  logic        s_axi_awvalid_i,
  output logic        s_axi_awready_o,
  input  logic [31:0] s_axi_wdata_i,
  input  logic [3:0]  s_axi_wstrb_i,
  input  logic        s_axi_wvalid_i,
  output logic        s_axi_wready_o,
  output logic        s_axi_bvalid_o,
  input  logic        s_axi_bready_i,
  input  logic [11:0] s_axi_araddr_i,
  input  logic        s_axi_arvalid_i,
  output logic        s_axi_arready_o,
  output logic [31:0] s_axi_rdata_o,
  output logic        s_axi_rvalid_o,
  input  logic        s_axi_rready_i,
  output logic        wr_en_o,
  output logic [11:2] wr_addr_o,
  output logic [31:0] wr_data_o,
  output logic [3:0]  wr_strb_o,
  output logic        rd_en_o,
  output logic [11:2] rd_addr_o,
  input  logic [31:0] rd_data_i
);

  axil_state_e state_q;
  logic        awready_q, wready_q, arready_q, bvalid_q, rvalid_q;
  logic [31:0] rdata_q;
  logic        wr_en_q, rd_en_q;
  logic [11:2] aw_addr_q, ar_addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;

  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{s_axi_awaddr_i[1:0], s_axi_araddr_i[1:0]};

  // Handshake outputs are registered from the next state; the cycle after reset
  // keeps them low so every output starts at 0.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      arready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      aw_addr_q <= '0;
      ar_addr_q <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      wr_en_q <= 1'b0;
      rd_en_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          awready_q <= 1'b1;
          wready_q  <= 1'b1;
          arready_q <= 1'b1;
          if (s_axi_awvalid_i && s_axi_wvalid_i && awready_q && wready_q) begin
            aw_addr_q <= s_axi_awaddr_i[11:2];
            wdata_q   <= s_axi_wdata_i;
            wstrb_q   <= s_axi_wstrb_i;
            wr_en_q   <= 1'b1;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            arready_q <= 1'b0;
            bvalid_q  <= 1'b1;
            state_q   <= ST_WRESP;
          end else if (s_axi_awvalid_i && awready_q) begin
            aw_addr_q <= s_axi_awaddr_i[11:2];
            awready_q <= 1'b0;
            arready_q <= 1'b0;
            state_q   <= ST_AW;
          end else if (s_axi_wvalid_i && wready_q) begin
            wdata_q   <= s_axi_wdata_i;
            wstrb_q   <= s_axi_wstrb_i;
            wready_q  <= 1'b0;
            arready_q <= 1'b0;
            state_q   <= ST_W;
          end else if (s_axi_arvalid_i && arready_q) begin
            ar_addr_q <= s_axi_araddr_i[11:2];
            rd_en_q   <= 1'b1;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            arready_q <= 1'b0;
            state_q   <= ST_RD;
          end
        end
        ST_AW: begin
          if (s_axi_wvalid_i) begin
            wdata_q  <= s_axi_wdata_i;
            wstrb_q  <= s_axi_wstrb_i;
            wr_en_q  <= 1'b1;
            wready_q <= 1'b0;
            bvalid_q <= 1'b1;
            state_q  <= ST_WRESP;
          end
        end
        ST_W: begin
          if (s_axi_awvalid_i) begin
            aw_addr_q <= s_axi_awaddr_i[11:2];
            wr_en_q   <= 1'b1;
            awready_q <= 1'b0;
            bvalid_q  <= 1'b1;
            state_q   <= ST_WRESP;
          end
        end
        ST_WRESP: begin
          if (s_axi_bready_i) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            arready_q <= 1'b1;
            state_q   <= ST_IDLE;
          end
        end
        ST_RD: begin
          rdata_q  <= rd_data_i;
          rvalid_q <= 1'b1;
          state_q  <= ST_RRESP;
        end
        ST_RRESP: begin
          if (s_axi_rready_i) begin
            rvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            arready_q <= 1'b1;
            state_q   <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign s_axi_awready_o = awready_q;
  assign s_axi_wready_o  = wready_q;
  assign s_axi_arready_o = arready_q;
  assign s_axi_bvalid_o  = bvalid_q;
  assign s_axi_rvalid_o  = rvalid_q;
  assign s_axi_rdata_o   = rdata_q;
  assign wr_en_o         = wr_en_q;
  assign wr_addr_o       = aw_addr_q;
  assign wr_data_o       = wdata_q;
  assign wr_strb_o       = wstrb_q;
  assign rd_en_o         = rd_en_q;
  assign rd_addr_o       = ar_addr_q;

endmodule

// File: rtl/hpu_ctrl_regs.sv
// AXI-Lite register file holding HPU run parameters, control bits, sticky status and user regs.
// Optional interrupt (CTRL[8] irq_en, irq output) is built when HPU_CTRL_IRQ_EN is defined.
module hpu_ctrl_regs
  import hpu_pkg::*;
#(
  parameter int                 NUM_USER     = 4,
  parameter logic [ADDR_W-1:0]  RST_ADDR_I   = 20'd109,
  parameter logic [ADDR_W-1:0]  RST_ADDR_J   = 20'd2,
  parameter logic [ITEM_W-1:0]  RST_ITEM_NUM = 16'd1000,
  parameter logic [31:0]        VERSION      = 32'h0002_0000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [11:0]             s_axi_awaddr,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [31:0]             s_axi_wdata,
  input  logic [3:0]              s_axi_wstrb,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [11:0]             s_axi_araddr,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [31:0]             s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready,
  input  logic                    gen_done,
  input  logic                    get_fin,
  output logic                    run,
  output logic                    gen,
  output logic [ADDR_W-1:0]       addr_i,
  output logic [ADDR_W-1:0]       addr_j,
  output logic [ITEM_W-1:0]       item_memory_num,
  output logic [32*NUM_USER-1:0]  user_regs,
  output logic                    irq
);

  localparam logic [7:0] USER_WBASE = USER_BASE[9:2];

  logic        wr_en, rd_en;
  logic [11:2] wr_addr, rd_addr;
  logic [31:0] wr_data, rd_mux;
  logic [3:0]  wr_strb;
  logic [11:0] wofs, rofs;

  logic              gen_q, gen_d, run_q, run_d;
  logic              done_q, done_d, gfs_q, gfs_d;
  logic [ADDR_W-1:0] addr_i_q, addr_i_d, addr_j_q, addr_j_d;
  logic [ITEM_W-1:0] item_q, item_d;
  logic [31:0]       user_q [NUM_USER];
  logic [31:0]       user_d [NUM_USER];
  logic [31:0]       ctrl_rd, status_rd, mrg;
  logic              ctrl_wr, stat_wr;

  axil_slave_fsm u_fsm (
    .clk_i           (clk),
    .rst_i           (rst),
    .s_axi_awaddr_i  (s_axi_awaddr),
    .s_axi_awvalid_i (s_axi_awvalid),
    .s_axi_awready_o (s_axi_awready),
    .s_axi_wdata_i   (s_axi_wdata),
    .s_axi_wstrb_i   (s_axi_wstrb),
    .s_axi_wvalid_i  (s_axi_wvalid),
    .s_axi_wready_o  (s_axi_wready),
    .s_axi_bvalid_o  (s_axi_bvalid),
    .s_axi_bready_i  (s_axi_bready),
    .s_axi_araddr_i  (s_axi_araddr),
    .s_axi_arvalid_i (s_axi_arvalid),
    .s_axi_arready_o (s_axi_arready),
    .s_axi_rdata_o   (s_axi_rdata),
    .s_axi_rvalid_o  (s_axi_rvalid),
    .s_axi_rready_i  (s_axi_rready),
    .wr_en_o         (wr_en),
    .wr_addr_o       (wr_addr),
    .wr_data_o       (wr_data),
    .wr_strb_o       (wr_strb),
    .rd_en_o         (rd_en),
    .rd_addr_o       (rd_addr),
    .rd_data_i       (rd_mux)
  );

  assign s_axi_bresp = 2'b00;
  assign s_axi_rresp = 2'b00;
  assign wofs = {wr_addr, 2'b00};
  assign rofs = {rd_addr, 2'b00};

`ifdef HPU_CTRL_IRQ_EN
  logic irq_en_q, irq_en_d, irq_q;
  assign ctrl_rd = {23'b0, irq_en_q, 6'b0, run_q, gen_q};
  assign irq     = irq_q;
`else
  assign ctrl_rd = {30'b0, run_q, gen_q};
  assign irq     = 1'b0;
`endif
  assign status_rd = {28'b0, gfs_q, done_q, run_q, gen_q};

  // Sticky bits: hardware set events are applied last so they beat software clears.
  always_comb begin
    gen_d    = gen_q;
    run_d    = run_q;
    done_d   = done_q;
    gfs_d    = gfs_q;
    addr_i_d = addr_i_q;
    addr_j_d = addr_j_q;
    item_d   = item_q;
    user_d   = user_q;
    mrg      = '0;
`ifdef HPU_CTRL_IRQ_EN
    irq_en_d = irq_en_q;
`endif
    ctrl_wr = wr_en && (wofs == CTRL_OFS);
    stat_wr = wr_en && (wofs == STATUS_OFS);

    if (gen_done) gen_d = 1'b0;
    if (ctrl_wr) begin
      mrg   = apply_strb(ctrl_rd, wr_data, wr_strb);
      gen_d = mrg[CTRL_GEN_BIT];
      run_d = mrg[CTRL_RUN_BIT];
`ifdef HPU_CTRL_IRQ_EN
      irq_en_d = mrg[CTRL_IRQ_EN_BIT];
`endif
    end
    if (ctrl_wr && wr_strb[0] && wr_data[CTRL_GEN_BIT]) done_d = 1'b0;
    if (stat_wr && wr_strb[0] && wr_data[STAT_DONE_BIT]) done_d = 1'b0;
    if (stat_wr && wr_strb[0] && wr_data[STAT_GFS_BIT])  gfs_d  = 1'b0;
    if (gen_done) done_d = 1'b1;
    if (get_fin)  gfs_d  = 1'b1;

    if (wr_en && (wofs == ADDR_I_OFS)) begin
      mrg      = apply_strb({{(32-ADDR_W){1'b0}}, addr_i_q}, wr_data, wr_strb);
      addr_i_d = mrg[ADDR_W-1:0];
    end
    if (wr_en && (wofs == ADDR_J_OFS)) begin
      mrg      = apply_strb({{(32-ADDR_W){1'b0}}, addr_j_q}, wr_data, wr_strb);
      addr_j_d = mrg[ADDR_W-1:0];
    end
    if (wr_en && (wofs == ITEM_NUM_OFS)) begin
      mrg    = apply_strb({{(32-ITEM_W){1'b0}}, item_q}, wr_data, wr_strb);
      item_d = mrg[ITEM_W-1:0];
    end
    for (int k = 0; k < NUM_USER; k++) begin
      if (wr_en && (wr_addr[11:10] == 2'b00) && (wr_addr[9:2] == USER_WBASE + 8'(k)))
        user_d[k] = apply_strb(user_q[k], wr_data, wr_strb);
    end
  end

  always_comb begin
    rd_mux = '0;
    if (rd_en) begin
      case (rofs)
        CTRL_OFS:     rd_mux = ctrl_rd;
        STATUS_OFS:   rd_mux = status_rd;
        ADDR_I_OFS:   rd_mux = {{(32-ADDR_W){1'b0}}, addr_i_q};
        ADDR_J_OFS:   rd_mux = {{(32-ADDR_W){1'b0}}, addr_j_q};
        ITEM_NUM_OFS: rd_mux = {{(32-ITEM_W){1'b0}}, item_q};
        VERSION_OFS:  rd_mux = VERSION;
        default:      rd_mux = '0;
      endcase
      for (int k = 0; k < NUM_USER; k++) begin
        if ((rd_addr[11:10] == 2'b00) && (rd_addr[9:2] == USER_WBASE + 8'(k)))
          rd_mux = user_q[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gen_q    <= 1'b0;
      run_q    <= 1'b0;
      done_q   <= 1'b0;
      gfs_q    <= 1'b0;
      addr_i_q <= RST_ADDR_I;
      addr_j_q <= RST_ADDR_J;
      item_q   <= RST_ITEM_NUM;
      for (int k = 0; k < NUM_USER; k++) user_q[k] <= '0;
    end else begin
      gen_q    <= gen_d;
      run_q    <= run_d;
      done_q   <= done_d;
      gfs_q    <= gfs_d;
      addr_i_q <= addr_i_d;
      addr_j_q <= addr_j_d;
      item_q   <= item_d;
      user_q   <= user_d;
    end
  end

`ifdef HPU_CTRL_IRQ_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      irq_en_q <= irq_en_d;
      irq_q    <= done_q & irq_en_q;
    end
  end
`endif

  assign gen             = gen_q;
  assign run             = run_q;
  assign addr_i          = addr_i_q;
  assign addr_j          = addr_j_q;
  assign item_memory_num = item_q;

  for (genvar g = 0; g < NUM_USER; g++) begin : g_user_out
    assign user_regs[32*g +: 32] = user_q[g];
  end

endmodule

// File: tb/tb_hpu_ctrl_regs.sv
// Directed bench for hpu_ctrl_regs: AXI-Lite reads/writes, strobes, sticky status, decode and reset.
module tb_hpu_ctrl_regs;

  localparam int NU = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [11:0]   s_axi_awaddr;
  logic          s_axi_awvalid;
  logic          s_axi_awready;
  logic [31:0]   s_axi_wdata;
  logic [3:0]    s_axi_wstrb;
  logic          s_axi_wvalid;
  logic          s_axi_wready;
  logic [1:0]    s_axi_bresp;
  logic          s_axi_bvalid;
  logic          s_axi_bready;
  logic [11:0]   s_axi_araddr;
  logic          s_axi_arvalid;
  logic          s_axi_arready;
  logic [31:0]   s_axi_rdata;
  logic [1:0]    s_axi_rresp;
  logic          s_axi_rvalid;
  logic          s_axi_rready;
  logic          gen_done;
  logic          get_fin;
  logic          run;
  logic          gen;
  logic [19:0]   addr_i;
  logic [19:0]   addr_j;
  logic [15:0]   item_memory_num;
  logic [32*NU-1:0] user_regs;
  logic          irq;

  int n_checks = 0;
  int n_fail   = 0;

  hpu_ctrl_regs #(.NUM_USER(NU)) dut (
    .clk             (clk),
    .rst             (rst),
    .s_axi_awaddr    (s_axi_awaddr),
    .s_axi_awvalid   (s_axi_awvalid),
    .s_axi_awready   (s_axi_awready),
    .s_axi_wdata     (s_axi_wdata),
    .s_axi_wstrb     (s_axi_wstrb),
    .s_axi_wvalid    (s_axi_wvalid),
    .s_axi_wready    (s_axi_wready),
    .s_axi_bresp     (s_axi_bresp),
    .s_axi_bvalid    (s_axi_bvalid),
    .s_axi_bready    (s_axi_bready),
    .s_axi_araddr    (s_axi_araddr),
    .s_axi_arvalid   (s_axi_arvalid),
    .s_axi_arready   (s_axi_arready),
    .s_axi_rdata     (s_axi_rdata),
    .s_axi_rresp     (s_axi_rresp),
    .s_axi_rvalid    (s_axi_rvalid),
    .s_axi_rready    (s_axi_rready),
    .gen_done        (gen_done),
    .get_fin         (get_fin),
    .run             (run),
    .gen             (gen),
    .addr_i          (addr_i),
    .addr_j          (addr_j),
    .item_memory_num (item_memory_num),
    .user_regs       (user_regs),
    .irq             (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Entered and left on a negedge; gd drives gen_done into the commit cycle.
  task automatic axi_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                           input logic gd);
    int n;
    s_axi_awaddr = a; s_axi_wdata = d; s_axi_wstrb = s;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_bready = 1'b1;
    n = 0;
    while (!(s_axi_awready && s_axi_wready) && n < 20) begin @(negedge clk); n++; end
    check("wr_hs_bound", 32'(n < 20), 32'd1);
    @(posedge clk); @(negedge clk);
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    gen_done = gd;
    check("bvalid", 32'(s_axi_bvalid), 32'd1);
    check("bresp", 32'(s_axi_bresp), 32'd0);
    @(posedge clk); @(negedge clk);
    gen_done = 1'b0;
  endtask

  task automatic axi_read(input logic [11:0] a, output logic [31:0] d, output int lat);
    int n;
    s_axi_araddr = a; s_axi_arvalid = 1'b1; s_axi_rready = 1'b1;
    n = 0;
    while (!s_axi_arready && n < 20) begin @(negedge clk); n++; end
    check("ar_hs_bound", 32'(n < 20), 32'd1);
    @(posedge clk); @(negedge clk);
    s_axi_arvalid = 1'b0;
    lat = 1;
    while (!s_axi_rvalid && lat < 20) begin @(negedge clk); lat++; end
    check("rvalid_bound", 32'(lat < 20), 32'd1);
    d = s_axi_rdata;
    check("rresp", 32'(s_axi_rresp), 32'd0);
    @(posedge clk); @(negedge clk);
  endtask

  initial begin
    logic [31:0] rd;
    int lat, n;
    rst = 1'b1;
    s_axi_awaddr = '0; s_axi_awvalid = 1'b0; s_axi_wdata = '0; s_axi_wstrb = '0;
    s_axi_wvalid = 1'b0; s_axi_bready = 1'b0; s_axi_araddr = '0; s_axi_arvalid = 1'b0;
    s_axi_rready = 1'b0; gen_done = 1'b0; get_fin = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_awready", 32'(s_axi_awready), 32'd0);
    check("rst_arready", 32'(s_axi_arready), 32'd0);
    check("rst_bvalid", 32'(s_axi_bvalid), 32'd0);
    check("rst_rvalid", 32'(s_axi_rvalid), 32'd0);
    check("rst_rdata", s_axi_rdata, 32'd0);
    check("rst_run_gen", {30'b0, run, gen}, 32'd0);
    check("rst_addr_i", 32'(addr_i), 32'd109);
    check("rst_addr_j", 32'(addr_j), 32'd2);
    check("rst_item", 32'(item_memory_num), 32'd1000);
    check("rst_user", 32'(|user_regs), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    axi_read(12'h008, rd, lat);
    check("rd_addr_i", rd, 32'd109);
    check("rd_latency", 32'(lat), 32'd2);
    axi_read(12'h00C, rd, lat);
    check("rd_addr_j", rd, 32'd2);
    axi_read(12'h010, rd, lat);
    check("rd_item", rd, 32'd1000);
    axi_read(12'h014, rd, lat);
    check("rd_version", rd, 32'h0002_0000);

    // AW leads W by one cycle; response held while bready low.
    s_axi_awaddr = 12'h010; s_axi_awvalid = 1'b1; s_axi_bready = 1'b0;
    n = 0;
    while (!s_axi_awready && n < 20) begin @(negedge clk); n++; end
    check("aw_hs_bound", 32'(n < 20), 32'd1);
    @(posedge clk); @(negedge clk);
    s_axi_awvalid = 1'b0;
    check("aw_state_wready", 32'(s_axi_wready), 32'd1);
    check("aw_state_awready", 32'(s_axi_awready), 32'd0);
    s_axi_wdata = 32'h0000_1234; s_axi_wstrb = 4'b0001; s_axi_wvalid = 1'b1;
    @(posedge clk); @(negedge clk);
    s_axi_wvalid = 1'b0;
    check("split_bvalid", 32'(s_axi_bvalid), 32'd1);
    @(posedge clk); @(negedge clk);
    check("split_bvalid_held", 32'(s_axi_bvalid), 32'd1);
    check("item_strb", 32'(item_memory_num), 32'h0334);
    s_axi_bready = 1'b1;
    @(posedge clk); @(negedge clk);
    check("split_bvalid_drop", 32'(s_axi_bvalid), 32'd0);

    // CTRL, gen auto-clear, done sticky and W1C.
    axi_write(12'h000, 32'd3, 4'hF, 1'b0);
    check("ctrl_gen", 32'(gen), 32'd1);
    check("ctrl_run", 32'(run), 32'd1);
    gen_done = 1'b1;
    @(negedge clk);
    gen_done = 1'b0;
    check("gen_autoclr", 32'(gen), 32'd0);
    check("run_kept", 32'(run), 32'd1);
    axi_read(12'h004, rd, lat);
    check("status_done", rd, 32'h6);
    axi_write(12'h004, 32'h4, 4'hF, 1'b0);
    axi_read(12'h004, rd, lat);
    check("status_w1c", rd, 32'h2);

    get_fin = 1'b1;
    @(negedge clk);
    get_fin = 1'b0;
    axi_read(12'h004, rd, lat);
    check("status_gfs", rd, 32'hA);
    axi_write(12'h004, 32'h8, 4'b0000, 1'b0);
    axi_read(12'h004, rd, lat);
    check("w1c_no_strb", rd, 32'hA);
    axi_write(12'h004, 32'h8, 4'b0001, 1'b0);
    axi_read(12'h004, rd, lat);
    check("w1c_gfs", rd, 32'h2);

    // CTRL gen write coincident with gen_done.
    axi_write(12'h000, 32'd3, 4'hF, 1'b1);
    check("coinc_gen", 32'(gen), 32'd1);
    axi_read(12'h004, rd, lat);
    check("coinc_status", rd, 32'h7);

    // Write, write data and read address all presented together: write first.
    s_axi_awaddr = 12'h020; s_axi_wdata = 32'hA5A5_5A5A; s_axi_wstrb = 4'hF;
    s_axi_araddr = 12'h020;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_arvalid = 1'b1;
    s_axi_bready = 1'b1; s_axi_rready = 1'b1;
    n = 0;
    while (!(s_axi_awready && s_axi_wready && s_axi_arready) && n < 20) begin
      @(negedge clk); n++;
    end
    check("tri_hs_bound", 32'(n < 20), 32'd1);
    @(posedge clk); @(negedge clk);
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    check("tri_bvalid", 32'(s_axi_bvalid), 32'd1);
    check("tri_rvalid", 32'(s_axi_rvalid), 32'd0);
    n = 0;
    while (!s_axi_arready && n < 20) begin @(negedge clk); n++; end
    check("tri_ar_bound", 32'(n < 20), 32'd1);
    @(posedge clk); @(negedge clk);
    s_axi_arvalid = 1'b0;
    n = 0;
    while (!s_axi_rvalid && n < 20) begin @(negedge clk); n++; end
    check("tri_rvalid_bound", 32'(n < 20), 32'd1);
    check("tri_rdata", s_axi_rdata, 32'hA5A5_5A5A);
    @(posedge clk); @(negedge clk);
    check("user0_out", user_regs[31:0], 32'hA5A5_5A5A);

    // Undecoded region, out-of-range user register, user byte strobes.
    axi_write(12'h408, 32'h000F_FFFF, 4'hF, 1'b0);
    check("undec_addr_i", 32'(addr_i), 32'd109);
    axi_write(12'h400, 32'h0, 4'hF, 1'b0);
    check("undec_run", 32'(run), 32'd1);
    axi_read(12'h400, rd, lat);
    check("undec_rd400", rd, 32'd0);
    axi_read(12'h408, rd, lat);
    check("undec_rd408", rd, 32'd0);
    axi_read(12'h030, rd, lat);
    check("user_oob", rd, 32'd0);
    axi_write(12'h02C, 32'h1234_5678, 4'b1100, 1'b0);
    axi_read(12'h02C, rd, lat);
    check("user3_strb", rd, 32'h1234_0000);
    check("user3_out", user_regs[127:96], 32'h1234_0000);

    // Interrupt path.
    axi_write(12'h004, 32'h4, 4'h1, 1'b0);
    axi_write(12'h000, 32'h102, 4'hF, 1'b0);
    axi_read(12'h000, rd, lat);
`ifdef HPU_CTRL_IRQ_EN
    check("ctrl_irq_en", rd, 32'h102);
`else
    check("ctrl_irq_en", rd, 32'h002);
`endif
    gen_done = 1'b1;
    @(negedge clk);
    gen_done = 1'b0;
    check("irq_lag", 32'(irq), 32'd0);
    @(negedge clk);
`ifdef HPU_CTRL_IRQ_EN
    check("irq_set", 32'(irq), 32'd1);
`else
    check("irq_set", 32'(irq), 32'd0);
`endif
    axi_write(12'h004, 32'h4, 4'h1, 1'b0);
`ifdef HPU_CTRL_IRQ_EN
    check("irq_hold", 32'(irq), 32'd1);
`else
    check("irq_hold", 32'(irq), 32'd0);
`endif
    @(negedge clk);
    check("irq_clr", 32'(irq), 32'd0);

    // Reset while a read response is pending.
    s_axi_araddr = 12'h008; s_axi_arvalid = 1'b1; s_axi_rready = 1'b0;
    n = 0;
    while (!s_axi_arready && n < 20) begin @(negedge clk); n++; end
    check("rr_ar_bound", 32'(n < 20), 32'd1);
    @(posedge clk); @(negedge clk);
    s_axi_arvalid = 1'b0;
    n = 0;
    while (!s_axi_rvalid && n < 20) begin @(negedge clk); n++; end
    check("rr_rvalid", 32'(s_axi_rvalid), 32'd1);
    check("rr_rdata", s_axi_rdata, 32'd109);
    @(negedge clk);
    check("rr_rdata_held", s_axi_rdata, 32'd109);
    rst = 1'b1;
    @(negedge clk);
    check("rr_rst_rvalid", 32'(s_axi_rvalid), 32'd0);
    check("rr_rst_run", 32'(run), 32'd0);
    check("rr_rst_item", 32'(item_memory_num), 32'd1000);
    check("rr_rst_user", 32'(|user_regs), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    axi_read(12'h004, rd, lat);
    check("post_rst_status", rd, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hpu_ctrl_regs.md
Name: hpu_ctrl_regs

Overview:
- AXI-Lite slave register file that replaces the hard-wired HPU run parameters (addr_i, addr_j, item_memory_num) and run/gen control with software-programmable registers.
- Adds byte-strobe writes, a read-only status word, a sticky done flag and NUM_USER generic scratch/user registers.
- Sits between the PS AXI-Lite port and the HPU datapath (get/stream/core control).
- Single clock domain; the datapath and AXI-Lite share clk.

Parameters:
- NUM_USER, 4, number of 32-bit user registers at 0x20+4k (1..32).
- RST_ADDR_I, 20'd109, reset value of ADDR_I.
- RST_ADDR_J, 20'd2, reset value of ADDR_J.
- RST_ITEM_NUM, 16'd1000, reset value of ITEM_NUM.
- VERSION, 32'h0002_0000, constant returned at 0x14.

Ports:
- clk  in  1  sole clock (AXI-Lite and datapath)
- rst  in  1  synchronous, active-high reset
- s_axi_awaddr  in  12  write address; bits [1:0] ignored
- s_axi_awvalid in 1, s_axi_awready out 1
- s_axi_wdata  in  32
- s_axi_wstrb  in  4
- s_axi_wvalid in 1, s_axi_wready out 1
- s_axi_bresp out 2, s_axi_bvalid out 1, s_axi_bready in 1
- s_axi_araddr  in  12
- s_axi_arvalid in 1, s_axi_arready out 1
- s_axi_rdata out 32, s_axi_rresp out 2, s_axi_rvalid out 1, s_axi_rready in 1
- gen_done  in  1  one-cycle pulse: item-memory generation finished
- get_fin  in  1  one-cycle pulse: stream get phase finished
- run, gen  out  1 each  control bits to datapath
- addr_i  out  20
- addr_j  out  20
- item_memory_num  out  16
- user_regs  out  32*NUM_USER  flattened; reg k occupies [32k+31:32k]
- irq  out  1  see Optional Feature

Behaviour:
- Reset values: every AXI-Lite output = 0; run = gen = 0; addr_i = RST_ADDR_I; addr_j = RST_ADDR_J; item_memory_num = RST_ITEM_NUM; user_regs = 0; done = 0; irq = 0.
- FSM states and handshakes:
  - IDLE: awready = wready = arready = 1.
  - AW: wready = 1. W: awready = 1.
  - WRESP: bvalid = 1. RD: no handshake signals asserted. RRESP: rvalid = 1.
- FSM transitions:
  - IDLE: awvalid & wvalid -> WRESP; else awvalid -> AW; else wvalid -> W; else arvalid -> RD. Write beats read when both are presented.
  - AW -> WRESP on wvalid. W -> WRESP on awvalid.
  - WRESP -> IDLE on bready; the register update happens in the cycle WRESP is entered + 1, i.e. while in WRESP, exactly once.
  - RD -> RRESP, capturing rdata (read latency 2 cycles from the AR handshake).
  - RRESP -> IDLE on rready.
  - rdata is held stable while rvalid = 1. bresp = rresp = 2'b00 always.
- Decode: only awaddr[11:10] == 0 is decoded. Other addresses: writes are ignored, reads return 0, response is still OKAY.
- Register map (byte offset):
  - 0x00 CTRL RW: [0] gen, [1] run.
  - 0x04 STATUS: [0] gen, [1] run, [2] done (W1C), [3] get_fin_seen (W1C); other bits read 0.
  - 0x08 ADDR_I [19:0] RW.
  - 0x0C ADDR_J [19:0] RW.
  - 0x10 ITEM_NUM [15:0] RW.
  - 0x14 VERSION RO.
  - 0x20+4k USER[k] RW, k < NUM_USER; unmapped k reads 0.
  - Unused bits of every register read 0.
- WSTRB: byte lane b is written only if wstrb[b] = 1. This applies to RW fields and to the W1C bits (STATUS bits live in lane 0).
- gen auto-clear: gen_done = 1 clears gen on the next edge. If a CTRL write commits in the same cycle, the software write wins.
- done: set by gen_done. Cleared by a CTRL write with wdata[0] = 1 (new generation start) or by W1C. Set beats clear when both happen in the same cycle.
- get_fin_seen: set by get_fin, cleared by W1C. Set beats clear.
- rst asserted mid-transaction: FSM returns to IDLE immediately, any pending response is dropped, and all registers take their reset values.

Optional Feature:
- Macro: HPU_CTRL_IRQ_EN.
- When defined:
  - CTRL[8] becomes irq_en (RW, reset 0).
  - irq = registered (done & irq_en), i.e. asserted 1 cycle after done sets.
  - irq drops 1 cycle after done is cleared.
- When undefined: CTRL[8] reads 0 and ignores writes; irq is tied 0.

Decomposition:
- Shared package hpu_pkg holds:
  - register offset localparams (CTRL_OFS, STATUS_OFS, ADDR_I_OFS, ADDR_J_OFS, ITEM_NUM_OFS, VERSION_OFS, USER_BASE);
  - CTRL/STATUS bit-index constants;
  - field widths (ADDR_W = 20, ITEM_W = 16).
- One natural sub-module, axil_slave_fsm: handshake FSM, address/data capture, and the output strobes wr_en, wr_addr, wr_data, wr_strb, rd_en, rd_addr.
- The register file, decode and sticky logic stay in hpu_ctrl_regs.

Test Plan:
- Reset, then read 0x08 / 0x0C / 0x10 / 0x14 -> 109, 2, 1000, 32'h0002_0000; bresp = rresp = 0.
- AW one cycle before W, write 0x10 = 0x0000_1234 with wstrb = 4'b0001 -> item_memory_num = 0x03E8 becomes 0x03 in the high byte, 0x34 in the low byte, i.e. 0x0334; one bvalid pulse.
- Write CTRL = 3, then pulse gen_done -> gen = 0 next cycle, run = 1, STATUS reads 0x6; write STATUS = 0x4 -> STATUS reads 0x2.
- CTRL write of gen = 1 coincident with gen_done -> gen = 1, done = 1. Also: awvalid, wvalid and arvalid all asserted in IDLE -> write served first, then read.
- Write to 0x400, then read 0x400 -> write ignored, rdata = 0, OKAY. Read USER[NUM_USER] -> 0. rst during RRESP -> rvalid = 0 next cycle.
- With HPU_CTRL_IRQ_EN: set irq_en, pulse gen_done -> irq = 1 one cycle after done; W1C of done -> irq = 0 one cycle after the clear. Without the macro -> irq = 0 throughout.
